// File: rtl/immgen_pkg.sv
// Shared types for the RV32I immediate generator: format tags, opcode constants
// and the shift-funct3 helper.
package immgen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_SH   = 3'd3,
        FMT_S    = 3'd4,
        FMT_B    = 3'd5,
        FMT_U    = 3'd6,
        FMT_J    = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    // SLLI/SRLI/SRAI share OP_IMM but carry a shift amount instead of an immediate
    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/immgen_decode.sv
// Combinational RV32I immediate decode: instruction word -> sign-extended
// immediate, format tag and illegal-opcode flag.
module immgen_decode
    import immgen_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic [31:0]      instr,
    output logic [Width-1:0] imm,
    output fmt_e             fmt,
    output logic             illegal
);

    // Sign fill first, then overwrite the low bits each format defines
    always_comb begin
        imm     = {Width{instr[31]}};
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_JALR, OP_SYS: begin
                fmt       = FMT_I;
                imm[11:0] = instr[31:20];
            end
            OP_IMM: begin
                if (is_shift_f3(instr[14:12])) begin
                    fmt      = FMT_SH;
                    imm      = {Width{1'b0}};
                    imm[4:0] = instr[24:20];
                end else begin
                    fmt       = FMT_I;
                    imm[11:0] = instr[31:20];
                end
            end
            OP_STORE: begin
                fmt       = FMT_S;
                imm[11:0] = {instr[31:25], instr[11:7]};
            end
            OP_BR: begin
                fmt       = FMT_B;
                imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_JAL: begin
                fmt       = FMT_J;
                imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt       = FMT_U;
                imm[31:0] = {instr[31:12], 12'h000};
            end
            OP_REG: begin
                fmt = FMT_R;
                imm = {Width{1'b0}};
            end
            default: begin
                fmt     = FMT_NONE;
                imm     = {Width{1'b0}};
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/immgen_pipe.sv
// Registered RV32I immediate generator with a DEPTH-entry output FIFO behind
// valid/ready handshakes. Define IMMGEN_ILLEGAL_CNT_EN for the illegal_cnt port.
module immgen_pipe
    import immgen_pkg::*;
#(
    parameter int Width = 32,
    parameter int DEPTH = 2
`ifdef IMMGEN_ILLEGAL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      In,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_imm,
    output fmt_e             out_fmt,
    output logic             out_illegal
`ifdef IMMGEN_ILLEGAL_CNT_EN
    ,
    output logic [CNT_W-1:0] illegal_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [Width-1:0] dec_imm_s;
    fmt_e             dec_fmt_s;
    logic             dec_illegal_s;
    logic             push_s;
    logic             pop_s;

    logic [Width-1:0] imm_mem_r [DEPTH];
    fmt_e             fmt_mem_r [DEPTH];
    logic [DEPTH-1:0] ill_mem_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CW-1:0]    count_r;

    immgen_decode #(.Width(Width)) u_decode (
        .instr   (In),
        .imm     (dec_imm_s),
        .fmt     (dec_fmt_s),
        .illegal (dec_illegal_s)
    );

    // in_ready depends only on occupancy, so no path from out_ready
    assign in_ready  = (count_r != CW'(DEPTH));
    assign out_valid = (count_r != {CW{1'b0}});
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; stale contents are masked by count so they need no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            imm_mem_r[wr_ptr_r] <= dec_imm_s;
            fmt_mem_r[wr_ptr_r] <= dec_fmt_s;
            ill_mem_r[wr_ptr_r] <= dec_illegal_s;
        end
    end

    // Head presentation, forced to zero while empty
    always_comb begin
        out_imm     = {Width{1'b0}};
        out_fmt     = FMT_NONE;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_imm     = imm_mem_r[rd_ptr_r];
            out_fmt     = fmt_mem_r[rd_ptr_r];
            out_illegal = ill_mem_r[rd_ptr_r];
        end else begin
            out_imm     = {Width{1'b0}};
            out_fmt     = FMT_NONE;
            out_illegal = 1'b0;
        end
    end

`ifdef IMMGEN_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] illegal_cnt_r;

    // Saturating count of accepted words carrying an unknown opcode
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_cnt_r <= {CNT_W{1'b0}};
        end else if (push_s && dec_illegal_s && (illegal_cnt_r != {CNT_W{1'b1}})) begin
            illegal_cnt_r <= illegal_cnt_r + CNT_W'(1);
        end else begin
            illegal_cnt_r <= illegal_cnt_r;
        end
    end

    assign illegal_cnt = illegal_cnt_r;
`endif

endmodule
